// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame control unit: state codes and mode codes.
// State codes double as the debug encoding shown on db_estado.
package sobel_pkg;

  typedef enum logic [3:0] {
    EST_INICIAL    = 4'h0,
    EST_OCIOSO     = 4'h1,
    EST_RECEBE     = 4'h2,
    EST_PROCESSA   = 4'h3,
    EST_PREPARA_TX = 4'h4,
    EST_TRANSMITE  = 4'h5,
    EST_ERRO       = 4'h6,
    EST_ILEGAL     = 4'hE
  } estado_t;

  localparam logic [1:0] MODO_SOBEL = 2'b00;
  localparam logic [1:0] MODO_PASSA = 2'b01;

  // Reserved mode codes fall back to Sobel.
  function automatic logic [1:0] modo_valido(input logic [1:0] m);
    return (m == MODO_PASSA) ? MODO_PASSA : MODO_SOBEL;
  endfunction

endpackage

// File: rtl/sobel_uc_quadro_if.sv
// Control/status bundle between the frame control unit and the UART, RAM and Sobel blocks.
// master = control unit side, slave = peripheral side.
interface sobel_uc_quadro_if #(
  parameter int ADDR_W = 12
);
  logic              iniciar;
  logic              continuo;
  logic [1:0]        modo;
  logic              rx_pronto;
  logic              tx_pronto;
  logic              sobel_fim_imagem;
  logic              rx_enable;
  logic              mem_escreve;
  logic              sobel_calcula;
  logic              tx_enable;
  logic              tx_partida;
  logic              sel_bruto;
  logic [ADDR_W-1:0] endereco;
  logic [7:0]        quadros;
  logic              erro;
  logic [3:0]        db_estado;

  modport master (
    input  iniciar, continuo, modo, rx_pronto, tx_pronto, sobel_fim_imagem,
    output rx_enable, mem_escreve, sobel_calcula, tx_enable, tx_partida, sel_bruto,
           endereco, quadros, erro, db_estado
  );

  modport slave (
    output iniciar, continuo, modo, rx_pronto, tx_pronto, sobel_fim_imagem,
    input  rx_enable, mem_escreve, sobel_calcula, tx_enable, tx_partida, sel_bruto,
           endereco, quadros, erro, db_estado
  );
endinterface

// File: rtl/sobel_contador.sv
// Wrapping up-counter with synchronous clear (priority over enable) and terminal-count flag.
// fim is high while the count equals MAX.
module sobel_contador #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         fim
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= q + 1'b1;
  end

  assign fim = (q == W'(MAX));

endmodule

// File: rtl/sobel_uc_quadro.sv
// Frame sequencer: receive N_PIXELS bytes, optionally run Sobel, transmit, count frames.
// Owns the shared pixel address and aborts a stalled reception after TIMEOUT_CICLOS idle cycles.
module sobel_uc_quadro
  import sobel_pkg::*;
#(
  parameter int N_PIXELS       = 4096,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic              clock,
  input  logic              reset_n,
  sobel_uc_quadro_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  estado_t           estado, estado_prox;
  logic [1:0]        modo_reg;
  logic [7:0]        quadros_q;
  logic              erro_q;
  logic [ADDR_W-1:0] endereco;
  logic              end_fim, end_clr, end_en;
  logic [TW-1:0]     tmo_q;
  logic              tmo_fim, tmo_clr, tmo_en;
  logic              captura_modo, conta_quadro, seta_erro, limpa_erro;
  logic              rx_enable, mem_escreve, sobel_calcula, tx_enable, tx_partida;
  logic [3:0]        db_estado;

  sobel_contador #(.W(ADDR_W), .MAX(N_PIXELS - 1)) u_endereco (
    .clock(clock), .reset_n(reset_n), .clr(end_clr), .en(end_en),
    .q(endereco), .fim(end_fim)
  );

  // Idle timer only runs once the first byte of a frame has arrived.
  assign tmo_clr = bus.rx_pronto || (endereco == '0) || (estado != EST_RECEBE);
  assign tmo_en  = (estado == EST_RECEBE);

  sobel_contador #(.W(TW), .MAX(TIMEOUT_CICLOS)) u_timeout (
    .clock(clock), .reset_n(reset_n), .clr(tmo_clr), .en(tmo_en),
    .q(tmo_q), .fim(tmo_fim)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= EST_INICIAL;
      modo_reg  <= MODO_SOBEL;
      quadros_q <= 8'd0;
      erro_q    <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (captura_modo) modo_reg  <= modo_valido(bus.modo);
      if (conta_quadro) quadros_q <= quadros_q + 8'd1;
      if (seta_erro)       erro_q <= 1'b1;
      else if (limpa_erro) erro_q <= 1'b0;
    end
  end

  always_comb begin
    estado_prox   = estado;
    end_clr       = 1'b0;
    end_en        = 1'b0;
    captura_modo  = 1'b0;
    conta_quadro  = 1'b0;
    seta_erro     = 1'b0;
    limpa_erro    = 1'b0;
    rx_enable     = 1'b0;
    mem_escreve   = 1'b0;
    sobel_calcula = 1'b0;
    tx_enable     = 1'b0;
    tx_partida    = 1'b0;
    db_estado     = estado;
    case (estado)
      EST_INICIAL: begin
        end_clr     = 1'b1;
        estado_prox = EST_OCIOSO;
      end
      EST_OCIOSO: begin
        if (bus.iniciar) begin
          captura_modo = 1'b1;
          end_clr      = 1'b1;
          limpa_erro   = 1'b1;
          estado_prox  = EST_RECEBE;
        end
      end
      EST_RECEBE: begin
        rx_enable   = 1'b1;
        mem_escreve = bus.rx_pronto;
        // An arriving byte takes precedence over an expiring timer.
        if (bus.rx_pronto) begin
          if (end_fim) begin
            end_clr     = 1'b1;
            estado_prox = (modo_reg == MODO_PASSA) ? EST_PREPARA_TX : EST_PROCESSA;
          end else begin
            end_en = 1'b1;
          end
        end else if (tmo_fim) begin
          seta_erro   = 1'b1;
          estado_prox = EST_ERRO;
        end
      end
      EST_PROCESSA: begin
        sobel_calcula = 1'b1;
        if (bus.sobel_fim_imagem) estado_prox = EST_PREPARA_TX;
      end
      EST_PREPARA_TX: begin
        tx_enable   = 1'b1;
        tx_partida  = 1'b1;
        estado_prox = EST_TRANSMITE;
      end
      EST_TRANSMITE: begin
        tx_enable = 1'b1;
        if (bus.tx_pronto) begin
          if (end_fim) begin
            end_clr      = 1'b1;
            conta_quadro = 1'b1;
            captura_modo = bus.continuo;
            estado_prox  = bus.continuo ? EST_RECEBE : EST_OCIOSO;
          end else begin
            end_en      = 1'b1;
            estado_prox = EST_PREPARA_TX;
          end
        end
      end
      EST_ERRO: begin
        estado_prox = EST_OCIOSO;
      end
      default: begin
        db_estado   = EST_ILEGAL;
        estado_prox = EST_INICIAL;
      end
    endcase
  end

  assign bus.rx_enable     = rx_enable;
  assign bus.mem_escreve   = mem_escreve;
  assign bus.sobel_calcula = sobel_calcula;
  assign bus.tx_enable     = tx_enable;
  assign bus.tx_partida    = tx_partida;
  assign bus.sel_bruto     = (modo_reg == MODO_PASSA);
  assign bus.endereco      = endereco;
  assign bus.quadros       = quadros_q;
  assign bus.erro          = erro_q;
  assign bus.db_estado     = db_estado;

endmodule

// File: tb/tb_sobel_uc_quadro.sv
// Directed bench for the Sobel frame control unit with N_PIXELS=4, TIMEOUT_CICLOS=10.
module tb_sobel_uc_quadro;
  import sobel_pkg::*;

  localparam int NP = 4;
  localparam int AW = 12;
  localparam int TO = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 clock = ~clock;

  sobel_uc_quadro_if #(.ADDR_W(AW)) bus ();

  sobel_uc_quadro #(.N_PIXELS(NP), .ADDR_W(AW), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_frame(input bit sobel_path, input logic [7:0] q_exp, input logic sel_exp);
    int partidas = 0;
    for (int i = 0; i < NP; i++) begin
      bus.rx_pronto = 1'b1;
      #1;
      n_cmp++;
      if (bus.mem_escreve !== 1'b1 || bus.endereco !== AW'(i)) begin
        n_err++;
        $display("FAIL rx_write[%0d]: mem_escreve=%b endereco=%0d, expected 1 / %0d", i, bus.mem_escreve, bus.endereco, i);
      end
      tick();
      bus.rx_pronto = 1'b0;
    end
    if (sobel_path) begin
      n_cmp++;
      if (bus.db_estado !== 4'd3 || bus.sobel_calcula !== 1'b1 || bus.endereco !== '0) begin
        n_err++;
        $display("FAIL enter_processa: db_estado=%0d sobel_calcula=%b endereco=%0d, expected 3/1/0", bus.db_estado, bus.sobel_calcula, bus.endereco);
      end
      bus.sobel_fim_imagem = 1'b1;
      tick();
      bus.sobel_fim_imagem = 1'b0;
    end
    n_cmp++;
    if (bus.db_estado !== 4'd4 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL enter_prepara_tx: db_estado=%0d endereco=%0d, expected 4/0", bus.db_estado, bus.endereco);
    end
    n_cmp++;
    if (bus.sel_bruto !== sel_exp) begin
      n_err++;
      $display("FAIL sel_bruto: got %b expected %b", bus.sel_bruto, sel_exp);
    end
    for (int i = 0; i < NP; i++) begin
      n_cmp++;
      if (bus.db_estado !== 4'd4 || bus.endereco !== AW'(i)) begin
        n_err++;
        $display("FAIL tx_prepara[%0d]: db_estado=%0d endereco=%0d, expected 4/%0d", i, bus.db_estado, bus.endereco, i);
      end
      if (bus.tx_partida === 1'b1) partidas++;
      tick();
      n_cmp++;
      if (bus.db_estado !== 4'd5 || bus.tx_enable !== 1'b1 || bus.tx_partida !== 1'b0) begin
        n_err++;
        $display("FAIL tx_transmite[%0d]: db_estado=%0d tx_enable=%b tx_partida=%b, expected 5/1/0", i, bus.db_estado, bus.tx_enable, bus.tx_partida);
      end
      bus.tx_pronto = 1'b1;
      tick();
      bus.tx_pronto = 1'b0;
    end
    n_cmp++;
    if (partidas !== NP) begin
      n_err++;
      $display("FAIL tx_partida_count: got %0d expected %0d", partidas, NP);
    end
    n_cmp++;
    if (bus.quadros !== q_exp || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL frame_end: quadros=%0d endereco=%0d, expected %0d/0", bus.quadros, bus.endereco, q_exp);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({bus.rx_enable, bus.mem_escreve, bus.sobel_calcula, bus.tx_enable, bus.tx_partida,
         bus.sel_bruto, bus.erro} !== 7'b0 || bus.db_estado !== 4'd0) begin
      n_err++;
      $display("FAIL reset_strobes: strobes=%b db_estado=%0d, expected 0/0",
               {bus.rx_enable, bus.mem_escreve, bus.sobel_calcula, bus.tx_enable, bus.tx_partida, bus.sel_bruto, bus.erro}, bus.db_estado);
    end
    n_cmp++;
    if (bus.endereco !== '0 || bus.quadros !== 8'd0) begin
      n_err++;
      $display("FAIL reset_counters: endereco=%0d quadros=%0d, expected 0/0", bus.endereco, bus.quadros);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL after_reset: db_estado=%0d expected 1", bus.db_estado);
    end
  endtask

  task automatic test_sobel_single();
    bus.modo = 2'b00; bus.continuo = 1'b0; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd2 || bus.rx_enable !== 1'b1 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL start_recebe: db_estado=%0d rx_enable=%b endereco=%0d, expected 2/1/0", bus.db_estado, bus.rx_enable, bus.endereco);
    end
    run_frame(1'b1, 8'd1, 1'b0);
    n_cmp++;
    if (bus.db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL sobel_single_end: db_estado=%0d expected 1", bus.db_estado);
    end
  endtask

  task automatic test_passthrough();
    bus.modo = 2'b01; bus.continuo = 1'b0; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    run_frame(1'b0, 8'd2, 1'b1);
    n_cmp++;
    if (bus.db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL passthrough_end: db_estado=%0d expected 1", bus.db_estado);
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    bus.modo = 2'b00; bus.continuo = 1'b1; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    bus.modo = 2'b01;
    run_frame(1'b1, 8'd1, 1'b0);
    n_cmp++;
    if (bus.db_estado !== 4'd2 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL rearm: db_estado=%0d endereco=%0d, expected 2/0", bus.db_estado, bus.endereco);
    end
    bus.continuo = 1'b0;
    run_frame(1'b0, 8'd2, 1'b1);
    n_cmp++;
    if (bus.db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL continuous_end: db_estado=%0d expected 1", bus.db_estado);
    end
  endtask

  task automatic test_timeout();
    int espera = 0;
    bus.modo = 2'b00; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    bus.rx_pronto = 1'b1;
    tick();
    bus.rx_pronto = 1'b0;
    repeat (TO) tick();
    n_cmp++;
    if (bus.db_estado !== 4'd2) begin
      n_err++;
      $display("FAIL timeout_early: db_estado=%0d expected 2", bus.db_estado);
    end
    // Timer has reached its limit; a byte on this very cycle must still be taken.
    bus.rx_pronto = 1'b1;
    tick();
    bus.rx_pronto = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd2 || bus.endereco !== AW'(2)) begin
      n_err++;
      $display("FAIL timeout_vs_rx: db_estado=%0d endereco=%0d, expected 2/2", bus.db_estado, bus.endereco);
    end
    while (bus.db_estado !== 4'd6 && espera < 30) begin
      tick();
      espera++;
    end
    n_cmp++;
    if (espera !== TO + 1) begin
      n_err++;
      $display("FAIL timeout_cycles: ERRO after %0d cycles, expected %0d", espera, TO + 1);
    end
    n_cmp++;
    if (bus.erro !== 1'b1 || bus.rx_enable !== 1'b0 || bus.tx_enable !== 1'b0) begin
      n_err++;
      $display("FAIL erro_state: erro=%b rx_enable=%b tx_enable=%b, expected 1/0/0", bus.erro, bus.rx_enable, bus.tx_enable);
    end
    tick();
    n_cmp++;
    if (bus.db_estado !== 4'd1 || bus.erro !== 1'b1) begin
      n_err++;
      $display("FAIL erro_to_ocioso: db_estado=%0d erro=%b, expected 1/1", bus.db_estado, bus.erro);
    end
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd2 || bus.erro !== 1'b0) begin
      n_err++;
      $display("FAIL erro_clear: db_estado=%0d erro=%b, expected 2/0", bus.db_estado, bus.erro);
    end
  endtask

  task automatic test_reset_mid_tx();
    apply_reset();
    bus.modo = 2'b00; bus.continuo = 1'b0; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int i = 0; i < NP; i++) begin
      bus.rx_pronto = 1'b1; tick(); bus.rx_pronto = 1'b0;
    end
    bus.sobel_fim_imagem = 1'b1; tick(); bus.sobel_fim_imagem = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.tx_pronto = 1'b1; tick(); bus.tx_pronto = 1'b0;
    end
    tick();
    n_cmp++;
    if (bus.db_estado !== 4'd5 || bus.endereco !== AW'(2)) begin
      n_err++;
      $display("FAIL pre_reset: db_estado=%0d endereco=%0d, expected 5/2", bus.db_estado, bus.endereco);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rx_enable, bus.sobel_calcula, bus.tx_enable, bus.tx_partida, bus.sel_bruto, bus.erro} !== 6'b0 ||
        bus.db_estado !== 4'd0 || bus.endereco !== '0 || bus.quadros !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset: db_estado=%0d endereco=%0d quadros=%0d tx_enable=%b, expected 0/0/0/0",
               bus.db_estado, bus.endereco, bus.quadros, bus.tx_enable);
    end
    #1;
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.db_estado !== 4'd1 || bus.quadros !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset: db_estado=%0d quadros=%0d, expected 1/0", bus.db_estado, bus.quadros);
    end
  endtask

  task automatic test_stray();
    bus.modo = 2'b00; bus.continuo = 1'b0; bus.iniciar = 1'b1;
    tick();
    tick();
    bus.iniciar = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd2 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL stray_iniciar: db_estado=%0d endereco=%0d, expected 2/0", bus.db_estado, bus.endereco);
    end
    for (int i = 0; i < NP; i++) begin
      bus.rx_pronto = 1'b1; tick(); bus.rx_pronto = 1'b0;
    end
    bus.rx_pronto = 1'b1; bus.tx_pronto = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_escreve !== 1'b0) begin
      n_err++;
      $display("FAIL stray_write: mem_escreve=%b expected 0", bus.mem_escreve);
    end
    tick();
    bus.rx_pronto = 1'b0; bus.tx_pronto = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd3 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL stray_processa: db_estado=%0d endereco=%0d, expected 3/0", bus.db_estado, bus.endereco);
    end
    bus.sobel_fim_imagem = 1'b1; tick(); bus.sobel_fim_imagem = 1'b0;
    bus.tx_pronto = 1'b1; tick(); bus.tx_pronto = 1'b0;
    n_cmp++;
    if (bus.db_estado !== 4'd5 || bus.endereco !== '0) begin
      n_err++;
      $display("FAIL stray_prepara: db_estado=%0d endereco=%0d, expected 5/0", bus.db_estado, bus.endereco);
    end
    bus.tx_pronto = 1'b1; tick(); bus.tx_pronto = 1'b0;
    for (int i = 1; i < NP; i++) begin
      tick();
      bus.tx_pronto = 1'b1; tick(); bus.tx_pronto = 1'b0;
    end
    n_cmp++;
    if (bus.db_estado !== 4'd1 || bus.quadros !== 8'd1) begin
      n_err++;
      $display("FAIL stray_end: db_estado=%0d quadros=%0d, expected 1/1", bus.db_estado, bus.quadros);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.modo = 2'b01; bus.continuo = 1'b1; bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int f = 0; f < 256; f++) begin
      if (f == 255) bus.continuo = 1'b0;
      for (int i = 0; i < NP; i++) begin
        bus.rx_pronto = 1'b1; tick(); bus.rx_pronto = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
        tick();
        bus.tx_pronto = 1'b1; tick(); bus.tx_pronto = 1'b0;
      end
      if (f == 254) begin
        n_cmp++;
        if (bus.quadros !== 8'd255) begin
          n_err++;
          $display("FAIL wrap_255: quadros=%0d expected 255", bus.quadros);
        end
      end
    end
    n_cmp++;
    if (bus.quadros !== 8'd0 || bus.db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL wrap_0: quadros=%0d db_estado=%0d, expected 0/1", bus.quadros, bus.db_estado);
    end
  endtask

  initial begin
    bus.iniciar          = 1'b0;
    bus.continuo         = 1'b0;
    bus.modo             = 2'b00;
    bus.rx_pronto        = 1'b0;
    bus.tx_pronto        = 1'b0;
    bus.sobel_fim_imagem = 1'b0;
    test_reset();
    test_sobel_single();
    test_passthrough();
    test_continuous();
    test_timeout();
    test_reset_mid_tx();
    test_stray();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_uc_quadro.md
# sobel_uc_quadro

Parametrised frame-level control unit for the Sobel pipeline. It sequences receive, process and transmit of one image over the serial link. It owns the pixel address counter shared by the image buffers, selects Sobel or passthrough mode per frame, supports single-shot or continuous operation, counts completed frames, and aborts a stalled reception with a timeout. It sits between the UART rx/tx blocks, the image RAMs and the Sobel datapath.

## Interface
- N_PIXELS, 4096: pixels per frame (one byte each); must be at least 2.
- ADDR_W, 12: address width; satisfies 2^ADDR_W >= N_PIXELS.
- TIMEOUT_CICLOS, 50000000: maximum idle cycles between received bytes once a frame has started; must be at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  start pulse; acted on only in OCIOSO.
- continuo  in  1  1 = re-arm reception automatically after each frame.
- modo  in  2  00 Sobel, 01 passthrough; 10/11 are treated as 00.
- rx_pronto  in  1  one-cycle pulse: byte received.
- tx_pronto  in  1  one-cycle pulse: byte sent.
- sobel_fim_imagem  in  1  datapath has finished the frame.
- rx_enable  out  1  high in RECEBE.
- mem_escreve  out  1  equals rx_pronto while in RECEBE (combinational).
- sobel_calcula  out  1  high in PROCESSA.
- tx_enable  out  1  high in PREPARA_TX and TRANSMITE.
- tx_partida  out  1  high in PREPARA_TX (one cycle per byte).
- sel_bruto  out  1  tx reads the raw buffer; equals modo_reg == passthrough.
- endereco  out  ADDR_W  current pixel address.
- quadros  out  8  completed-frame count; wraps from 255 to 0.
- erro  out  1  sticky timeout flag.
- db_estado  out  4  state code.

## Operation
- States and db_estado codes: INICIAL 0, OCIOSO 1, RECEBE 2, PROCESSA 3, PREPARA_TX 4, TRANSMITE 5, ERRO 6. Any illegal encoding reports 4'hE and goes to INICIAL on the next clock.
- INICIAL goes to OCIOSO unconditionally.
- OCIOSO goes to RECEBE on iniciar. On this transition: modo is captured into modo_reg, endereco is cleared, and erro is cleared.
- RECEBE, on rx_pronto:
  - If endereco is below N_PIXELS-1, endereco increments.
  - Otherwise endereco is cleared. The next state is PROCESSA in Sobel mode, PREPARA_TX in passthrough mode.
- RECEBE timeout:
  - The timeout counter is cleared on every rx_pronto and whenever endereco is 0.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CICLOS, the next state is ERRO and erro is set.
- PROCESSA goes to PREPARA_TX on sobel_fim_imagem, with endereco at 0.
- PREPARA_TX goes to TRANSMITE unconditionally.
- TRANSMITE, on tx_pronto:
  - If endereco is below N_PIXELS-1, endereco increments and the next state is PREPARA_TX.
  - Otherwise quadros increments and endereco is cleared. The next state is RECEBE if continuo is 1, else OCIOSO.
  - On re-arm to RECEBE, modo is re-captured.
- ERRO: all strobes are low. Goes to OCIOSO after one cycle. erro stays high until the next accepted iniciar.
- Ignored inputs:
  - iniciar outside OCIOSO.
  - rx_pronto outside RECEBE.
  - tx_pronto outside TRANSMITE.
  - sobel_fim_imagem outside PROCESSA.

## Timing
- All outputs are Moore (registered state decode) except mem_escreve.
- While reset_n is low:
  - State is INICIAL and every output is 0 except db_estado=0.
  - endereco=0, quadros=0, erro=0, modo_reg=00, timeout counter=0.
- Reset asserted mid-frame aborts immediately. The frame is not counted.
- mem_escreve and endereco are valid in the same cycle. The address advances at the closing edge.
- The last received byte is written at N_PIXELS-1. The next cycle shows PROCESSA (or PREPARA_TX) with endereco=0.
- Per transmitted byte: one PREPARA_TX cycle, then TRANSMITE until tx_pronto.
- If a timeout and rx_pronto land in the same cycle, rx_pronto wins: the byte is accepted and the counter is cleared.
- A sobel_fim_imagem level held from the previous frame is ignored until PROCESSA.

## Structure
- Shared package sobel_pkg holds:
  - State codes (4-bit), including the illegal code 4'hE.
  - Mode codes MODO_SOBEL = 2'b00 and MODO_PASSA = 2'b01.
- Timeout counter width is $clog2(TIMEOUT_CICLOS+1).
- One sub-module, sobel_contador: a parametrised counter with clear, enable and terminal-count flag. It is instantiated for the address and for the timeout.

## Test plan
All scenarios use the overrides N_PIXELS=4 and TIMEOUT_CICLOS=10.
- Sobel single-shot: modo=00, continuo=0, iniciar, 4 rx_pronto pulses, sobel_fim_imagem, 4 tx_pronto pulses.
  - mem_escreve fires at addresses 0..3.
  - db_estado sequence is 1,2,3,4,5,...,1.
  - tx_partida pulses 4 times.
  - quadros=1 and sel_bruto=0.
- Passthrough: modo=01, 4 bytes received.
  - PROCESSA is never entered.
  - sel_bruto=1.
  - quadros increments after the 4th tx_pronto.
- Continuous: continuo=1 over two frames.
  - After the last tx_pronto, the state returns to RECEBE with endereco=0.
  - quadros goes 0→1→2.
  - modo changed between frames takes effect on the second frame.
- Timeout: 2 bytes received, then no rx_pronto for 10 cycles.
  - ERRO is entered and erro=1.
  - OCIOSO follows on the next cycle.
  - The next iniciar clears erro.
- Reset mid-transmit: reset_n pulsed low in TRANSMITE at endereco=2.
  - All outputs go to 0 and db_estado=0 asynchronously.
  - quadros is unchanged at 0.
- Stray inputs: rx_pronto in PROCESSA, tx_pronto in PREPARA_TX, iniciar in RECEBE.
  - No state or address change.
  - The quadros wrap from 255 to 0 is checked after 256 frames.
